// File: rtl/pattern_gen_if.sv
// Command-side and pin-side signal bundle for pattern_gen.
// master = command decoder / pin consumer, slave = pattern_gen.
interface pattern_gen_if #(
    parameter int CHLS = 32
);
    logic [23:0]     fdiv_i;
    logic            set_div_i;
    logic [CHLS-1:0] wr_data_i;
    logic            wr_en_i;
    logic            wr_clr_i;
    logic            start_i;
    logic            stop_i;
    logic            loop_i;
    logic [CHLS-1:0] data_o;
    logic            stb_o;
    logic            busy_o;
    logic            done_o;
    logic            full_o;

    modport master (
        output fdiv_i, set_div_i, wr_data_i, wr_en_i, wr_clr_i, start_i, stop_i, loop_i,
        input  data_o, stb_o, busy_o, done_o, full_o
    );

    modport slave (
        input  fdiv_i, set_div_i, wr_data_i, wr_en_i, wr_clr_i, start_i, stop_i, loop_i,
        output data_o, stb_o, busy_o, done_o, full_o
    );
endinterface

// File: rtl/pattern_gen.sv
// Pattern replay engine: stores up to DEPTH words, replays them one per r_div+1 clocks.
// Optional PGEN_IDLE_ZERO_EN: data_o is cleared on every RUN->IDLE transition.
//
// state | meaning
// IDLE  | pattern writable, outputs hold, waiting for start
// RUN   | replaying pattern at the divided rate, writes ignored
module pattern_gen #(
    parameter int CHLS  = 32,
    parameter int DEPTH = 16
) (
    input logic          clk_i,
    input logic          rst_in,
    pattern_gen_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [23:0]     r_div, cnt;
    logic [AW:0]     len, rd_ptr;
    logic            r_loop;
    logic [CHLS-1:0] mem [DEPTH];
    logic [CHLS-1:0] data_q;
    logic            stb_q, done_q;
    logic            full;
    logic            period_end;
    logic            do_start, do_next, do_wrap, do_done, do_stop;

    assign full        = (len == (AW+1)'(DEPTH));
    assign bus.data_o  = data_q;
    assign bus.stb_o   = stb_q;
    assign bus.done_o  = done_q;
    assign bus.busy_o  = (state_q == RUN);
    assign bus.full_o  = full;

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        period_end = (cnt >= r_div);
        do_start   = 1'b0;
        do_next    = 1'b0;
        do_wrap    = 1'b0;
        do_done    = 1'b0;
        do_stop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_i && !bus.stop_i && (len != '0)) begin
                    state_d  = RUN;
                    do_start = 1'b1;
                end
            end
            RUN: begin
                if (bus.stop_i) begin
                    state_d = IDLE;
                    do_stop = 1'b1;
                end else if (period_end) begin
                    if (rd_ptr < len) begin
                        do_next = 1'b1;
                    end else if (r_loop) begin
                        do_wrap = 1'b1;
                    end else begin
                        do_done = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pattern memory carries no reset; len alone defines the valid contents.
    always_ff @(posedge clk_i) begin
        if (state_q == IDLE && !bus.wr_clr_i && bus.wr_en_i && !full)
            mem[len[AW-1:0]] <= bus.wr_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            r_div  <= '0;
            cnt    <= '0;
            len    <= '0;
            rd_ptr <= '0;
            r_loop <= 1'b0;
            data_q <= '0;
            stb_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            stb_q  <= 1'b0;
            done_q <= 1'b0;
            if (bus.set_div_i)
                r_div <= bus.fdiv_i;
            if (state_q == IDLE) begin
                if (bus.wr_clr_i)
                    len <= '0;
                else if (bus.wr_en_i && !full)
                    len <= len + (AW+1)'(1);
            end
            if (do_start) begin
                data_q <= mem[0];
                stb_q  <= 1'b1;
                cnt    <= '0;
                rd_ptr <= (AW+1)'(1);
                r_loop <= bus.loop_i;
            end else if (state_q == RUN && !do_stop) begin
                cnt <= period_end ? 24'd0 : cnt + 24'd1;
            end
            if (do_next) begin
                data_q <= mem[rd_ptr[AW-1:0]];
                rd_ptr <= rd_ptr + (AW+1)'(1);
                stb_q  <= 1'b1;
            end
            if (do_wrap) begin
                data_q <= mem[0];
                rd_ptr <= (AW+1)'(1);
                stb_q  <= 1'b1;
            end
            if (do_done)
                done_q <= 1'b1;
`ifdef PGEN_IDLE_ZERO_EN
            if (do_done || do_stop)
                data_q <= '0;
`else
`endif
        end
    end
endmodule
